// File: rtl/alu_issue_seq.sv
// alu_issue_seq: runs one ALU request through READ, EXEC and WB, then retires it.
// Define DIV_ZERO_TRAP_EN to add a sticky div0_err trap for DIV/MOD by zero.

`ifndef ALU_NOP
`define ALU_NOP 0
`endif
`ifndef ALU_ADD
`define ALU_ADD 1
`endif
`ifndef ALU_SUB
`define ALU_SUB 2
`endif
`ifndef ALU_AND
`define ALU_AND 3
`endif
`ifndef ALU_OR
`define ALU_OR 4
`endif
`ifndef ALU_XOR
`define ALU_XOR 5
`endif
`ifndef ALU_DIV
`define ALU_DIV 10
`endif
`ifndef ALU_MOD
`define ALU_MOD 11
`endif
`ifndef ALU_CMP
`define ALU_CMP 12
`endif
`ifndef ALU_TST
`define ALU_TST 13
`endif

module alu_issue_seq #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_opcode,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [REG_AW-1:0] req_ra,
  input  logic [REG_AW-1:0] req_rb,
  input  logic [DATA_W-1:0] req_imm,
  input  logic              req_use_imm,
  output logic [REG_AW-1:0] rf_ra_addr,
  output logic [REG_AW-1:0] rf_rb_addr,
  input  logic [DATA_W-1:0] rf_ra_data,
  input  logic [DATA_W-1:0] rf_rb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  output logic              alu_enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags_q,
  output logic              done
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic              div0_err
`endif
);

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(`ALU_NOP);
  localparam logic [OP_W-1:0] OP_CMP = OP_W'(`ALU_CMP);
  localparam logic [OP_W-1:0] OP_TST = OP_W'(`ALU_TST);
`ifdef DIV_ZERO_TRAP_EN
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(`ALU_DIV);
  localparam logic [OP_W-1:0] OP_MOD = OP_W'(`ALU_MOD);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
  } req_t;

  state_t            state_q;
  state_t            state_d;
  req_t              req_q;
  logic [DATA_W-1:0] res_q;
  logic [3:0]        flg_q;
  logic              trap_q;
  logic              trap_d;
  logic              no_wb;
  logic              no_flags;

  // Read addresses follow the latched request; stable through READ.
  assign rf_ra_addr = req_q.ra;
  assign rf_rb_addr = req_q.rb;

  // Classify the latched opcode: which ops skip writeback or flags.
  always_comb begin
    no_wb    = 1'b0;
    no_flags = 1'b0;
    unique case (1'b1)
      (req_q.op == OP_NOP): begin
        no_wb    = 1'b1;
        no_flags = 1'b1;
      end
      (req_q.op == OP_CMP),
      (req_q.op == OP_TST): no_wb = 1'b1;
      default: ;
    endcase
  end

`ifdef DIV_ZERO_TRAP_EN
  logic div_op;
  assign div_op = (req_q.op == OP_DIV) || (req_q.op == OP_MOD);
  assign trap_d = div_op && (alu_b == '0);
`else
  assign trap_d = 1'b0;
`endif

  // State register; reset aborts any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-state strobes.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    alu_enable = 1'b0;
    done       = 1'b0;
    wb_en      = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_READ;
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: begin
        alu_enable = 1'b1;
        state_d    = S_WB;
      end
      S_WB: begin
        done    = 1'b1;
        wb_addr = req_q.rd;
        if (!no_wb && !trap_q) begin
          wb_en   = 1'b1;
          wb_data = res_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the request on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
    end else if (state_q == S_IDLE && req_valid) begin
      req_q.op      <= req_opcode;
      req_q.rd      <= req_rd;
      req_q.ra      <= req_ra;
      req_q.rb      <= req_rb;
      req_q.imm     <= req_imm;
      req_q.use_imm <= req_use_imm;
    end
  end

  // Load ALU operands at the end of READ; they hold afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else if (state_q == S_READ) begin
      alu_a      <= rf_ra_data;
      alu_b      <= req_q.use_imm ? req_q.imm : rf_rb_data;
      alu_opcode <= req_q.op;
    end
  end

  // Capture the ALU outputs at the end of EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '0;
      flg_q  <= '0;
      trap_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      res_q  <= alu_result;
      flg_q  <= alu_flags;
      trap_q <= trap_d;
    end
  end

  // Status register updates when the request retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (state_q == S_WB && !no_flags && !trap_q) begin
      flags_q <= flg_q;
    end
  end

`ifdef DIV_ZERO_TRAP_EN
  // Sticky divide-by-zero indicator, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div0_err <= 1'b0;
    end else if (state_q == S_WB && trap_q) begin
      div0_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: directed bench with a register-file/ALU environment,
// a transaction-level scoreboard and hand-computed literal checks.
`timescale 1ns/1ps
module tb_alu_issue_seq;

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5;
  localparam logic [4:0] OP_DIV = 5'd10;
  localparam logic [4:0] OP_MOD = 5'd11;
  localparam logic [4:0] OP_CMP = 5'd12;
  localparam logic [4:0] OP_TST = 5'd13;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opcode;
  logic [2:0]  req_rd, req_ra, req_rb;
  logic [15:0] req_imm;
  logic        req_use_imm;
  logic [2:0]  rf_ra_addr, rf_rb_addr;
  logic [15:0] rf_ra_data, rf_rb_data;
  logic [15:0] alu_a, alu_b;
  logic [4:0]  alu_opcode;
  logic        alu_enable;
  logic [15:0] alu_result;
  logic [3:0]  alu_flags;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [3:0]  flags_q;
  logic        done;
`ifdef DIV_ZERO_TRAP_EN
  logic        div0_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_rd(req_rd),
    .req_ra(req_ra), .req_rb(req_rb),
    .req_imm(req_imm), .req_use_imm(req_use_imm),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_enable(alu_enable),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flags_q(flags_q), .done(done)
`ifdef DIV_ZERO_TRAP_EN
    , .div0_err(div0_err)
`endif
  );

  // Stub ALU: {Z,N,C,O} + result. SUB/CMP report borrow in both C and O.
  function automatic logic [19:0] alu_f(input logic [4:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic c, o;
    s = '0; r = '0; c = 1'b0; o = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        c = s[16];
        o = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB, OP_CMP: begin
        r = a - b;
        c = (a < b);
        o = c;
      end
      OP_AND, OP_TST: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_DIV: r = (b == 16'h0) ? 16'hFFFF : a / b;
      OP_MOD: r = (b == 16'h0) ? a : a % b;
      default: r = '0;
    endcase
    if (op == OP_NOP) return 20'h0;
    return {(r == 16'h0), r[15], c, o, r};
  endfunction

  assign {alu_flags, alu_result} = alu_f(alu_opcode, alu_a, alu_b);

  // Register file environment: preload port plus DUT writeback.
  logic [15:0] rf [8];
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  initial for (int i = 0; i < 8; i++) rf[i] = '0;
  always @(posedge clk) begin
    if (ld_en) rf[ld_addr] <= ld_data;
    else if (wb_en) rf[wb_addr] <= wb_data;
  end
  assign rf_ra_data = rf[rf_ra_addr];
  assign rf_rb_data = rf[rf_rb_addr];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: each accepted request retires 3 cycles later.
  typedef struct {
    int          due;
    logic        wb;
    logic        upd;
    logic        trap;
    logic [2:0]  rd;
    logic [15:0] data;
    logic [3:0]  fl;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mreg [8];
  logic [3:0]  exp_fl;
  logic        exp_d0;
  int          cyc;

  initial begin
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    exp_fl = '0;
    exp_d0 = 1'b0;
    cyc = 0;
  end

  always @(negedge clk) begin : cmp
    exp_t        h, n;
    logic        rdy, due_now, ex_now;
    logic [15:0] a, b;
    logic [19:0] fr;
    logic        is_nop, quiet;
    if (rst) begin
      q.delete();
      exp_fl = '0;
      exp_d0 = 1'b0;
    end else begin
      cyc++;
      rdy = (q.size() == 0);
      due_now = 1'b0;
      ex_now = 1'b0;
      h = '{0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 4'd0};
      if (q.size() != 0) begin
        h = q[0];
        due_now = (h.due == cyc);
        ex_now = (h.due == cyc + 1);
      end
      chk("req_ready", {31'd0, req_ready}, {31'd0, rdy});
      chk("alu_enable", {31'd0, alu_enable}, {31'd0, ex_now});
      chk("done", {31'd0, done}, {31'd0, due_now});
      chk("wb_en", {31'd0, wb_en}, {31'd0, due_now && h.wb});
      chk("flags_q", {28'd0, flags_q}, {28'd0, exp_fl});
`ifdef DIV_ZERO_TRAP_EN
      chk("div0_err", {31'd0, div0_err}, {31'd0, exp_d0});
`endif
      if (due_now) begin
        chk("wb_addr", {29'd0, wb_addr}, {29'd0, h.rd});
        if (h.wb) begin
          chk("wb_data", {16'd0, wb_data}, {16'd0, h.data});
          mreg[h.rd] = h.data;
        end
        if (h.upd) exp_fl = h.fl;
        if (h.trap) exp_d0 = 1'b1;
        void'(q.pop_front());
      end
      if (ld_en) mreg[ld_addr] = ld_data;
      if (rdy && req_valid) begin
        a = mreg[req_ra];
        b = req_use_imm ? req_imm : mreg[req_rb];
        fr = alu_f(req_opcode, a, b);
        is_nop = (req_opcode == OP_NOP);
        quiet = is_nop || req_opcode == OP_CMP || req_opcode == OP_TST;
        n.due = cyc + 3;
        n.rd = req_rd;
        n.data = fr[15:0];
        n.fl = fr[19:16];
`ifdef DIV_ZERO_TRAP_EN
        n.trap = (req_opcode == OP_DIV || req_opcode == OP_MOD) && b == 16'h0;
`else
        n.trap = 1'b0;
`endif
        n.wb = !quiet && !n.trap;
        n.upd = !is_nop && !n.trap;
        q.push_back(n);
      end
    end
  end

  task automatic load(input logic [2:0] ad, input logic [15:0] d);
    ld_en = 1'b1;
    ld_addr = ad;
    ld_data = d;
    @(posedge clk);
    #2;
    ld_en = 1'b0;
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] rd,
                       input logic [2:0] ra, input logic [2:0] rb,
                       input logic [15:0] imm, input logic ui);
    req_opcode = op;
    req_rd = rd;
    req_ra = ra;
    req_rb = rb;
    req_imm = imm;
    req_use_imm = ui;
    req_valid = 1'b1;
  endtask

  task automatic wait_accept(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic [4:0] op, input logic [2:0] rd,
                     input logic [2:0] ra, input logic [2:0] rb,
                     input logic [15:0] imm, input logic ui,
                     output int lat, output logic wen,
                     output logic [2:0] wa, output logic [15:0] wd,
                     output logic [3:0] fl);
    logic ok;
    lat = 0; wen = 1'b0; wa = '0; wd = '0; fl = '0;
    drive(op, rd, ra, rb, imm, ui);
    wait_accept(ok);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    if (!ok) return;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        ok = 1'b1;
        wen = wb_en;
        wa = wb_addr;
        wd = wb_data;
        break;
      end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    fl = flags_q;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_wb_en"}, {31'd0, wb_en}, 32'd0);
    chk({tag, "_wb_addr"}, {29'd0, wb_addr}, 32'd0);
    chk({tag, "_wb_data"}, {16'd0, wb_data}, 32'd0);
    chk({tag, "_alu_en"}, {31'd0, alu_enable}, 32'd0);
    chk({tag, "_alu_a"}, {16'd0, alu_a}, 32'd0);
    chk({tag, "_alu_b"}, {16'd0, alu_b}, 32'd0);
    chk({tag, "_alu_op"}, {27'd0, alu_opcode}, 32'd0);
    chk({tag, "_flags"}, {28'd0, flags_q}, 32'd0);
    chk({tag, "_ra_addr"}, {29'd0, rf_ra_addr}, 32'd0);
`ifdef DIV_ZERO_TRAP_EN
    chk({tag, "_div0"}, {31'd0, div0_err}, 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, low;
    logic        wen, ok;
    logic [2:0]  wa;
    logic [15:0] wd, a_wd;
    logic [3:0]  fl;
    rst = 1'b1;
    req_valid = 1'b0;
    req_opcode = '0;
    req_rd = '0;
    req_ra = '0;
    req_rb = '0;
    req_imm = '0;
    req_use_imm = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_reset_outs("rst0");

    load(3'd1, 16'd3);
    load(3'd2, 16'd5);
    run(OP_ADD, 3'd4, 3'd1, 3'd2, 16'd0, 1'b0, lat, wen, wa, wd, fl);
    chk("add_latency", lat, 3);
    chk("add_wb_en", {31'd0, wen}, 32'd1);
    chk("add_wb_addr", {29'd0, wa}, 32'd4);
    chk("add_wb_data", {16'd0, wd}, 32'd8);
    chk("add_flags", {28'd0, fl}, 32'b0000);

    load(3'd1, 16'd5);
    run(OP_CMP, 3'd7, 3'd1, 3'd2, 16'd0, 1'b0, lat, wen, wa, wd, fl);
    chk("cmp_latency", lat, 3);
    chk("cmp_wb_en", {31'd0, wen}, 32'd0);
    chk("cmp_flags", {28'd0, fl}, 32'b1000);

    load(3'd1, 16'd2);
    run(OP_SUB, 3'd1, 3'd1, 3'd0, 16'd3, 1'b1, lat, wen, wa, wd, fl);
    chk("sub_wb_en", {31'd0, wen}, 32'd1);
    chk("sub_wb_data", {16'd0, wd}, 32'hFFFF);
    chk("sub_flags", {28'd0, fl}, 32'b0111);

    run(OP_NOP, 3'd3, 3'd4, 3'd4, 16'd0, 1'b0, lat, wen, wa, wd, fl);
    chk("nop_wb_en", {31'd0, wen}, 32'd0);
    chk("nop_flags_hold", {28'd0, fl}, 32'b0111);

    run(OP_XOR, 3'd2, 3'd4, 3'd0, 16'd8, 1'b1, lat, wen, wa, wd, fl);
    chk("xor_wb_data", {16'd0, wd}, 32'd0);
    chk("xor_flags", {28'd0, fl}, 32'b1000);

    // Back-to-back with valid held; second reads the first's rd.
    drive(OP_ADD, 3'd5, 3'd4, 3'd4, 16'd0, 1'b0);
    wait_accept(ok);
    @(posedge clk);
    #2;
    drive(OP_ADD, 3'd5, 3'd5, 3'd0, 16'd1, 1'b1);
    low = 0;
    a_wd = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) a_wd = wb_data;
      if (req_ready) break;
      low++;
    end
    chk("b2b_ready_low", low, 3);
    chk("b2b_first_data", {16'd0, a_wd}, 32'd16);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) break;
    end
    @(posedge clk);
    #1;
    chk("b2b_second_rf", {16'd0, rf[5]}, 32'd17);

    // Reset during EXEC aborts the request.
    #1;
    drive(OP_ADD, 3'd6, 3'd4, 3'd4, 16'd0, 1'b0);
    wait_accept(ok);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("exec_alu_en", {31'd0, alu_enable}, 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outs("rst_exec");
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_write", {16'd0, rf[6]}, 32'd0);

    run(OP_CMP, 3'd0, 3'd4, 3'd0, 16'd8, 1'b1, lat, wen, wa, wd, fl);
    chk("cmp2_flags", {28'd0, fl}, 32'b1000);
`ifdef DIV_ZERO_TRAP_EN
    run(OP_DIV, 3'd2, 3'd4, 3'd3, 16'd0, 1'b0, lat, wen, wa, wd, fl);
    chk("div0_wb_en", {31'd0, wen}, 32'd0);
    chk("div0_flags_hold", {28'd0, fl}, 32'b1000);
    chk("div0_err_set", {31'd0, div0_err}, 32'd1);
    run(OP_MOD, 3'd0, 3'd5, 3'd0, 16'd5, 1'b1, lat, wen, wa, wd, fl);
    chk("mod_wb_data", {16'd0, wd}, 32'd2);
    chk("div0_err_sticky", {31'd0, div0_err}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("div0_err_clear", {31'd0, div0_err}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
`else
    run(OP_DIV, 3'd2, 3'd4, 3'd3, 16'd0, 1'b0, lat, wen, wa, wd, fl);
    chk("div0_wb_en", {31'd0, wen}, 32'd1);
    chk("div0_wb_data", {16'd0, wd}, 32'hFFFF);
    chk("div0_flags", {28'd0, fl}, 32'b0100);
    run(OP_MOD, 3'd0, 3'd5, 3'd0, 16'd5, 1'b1, lat, wen, wa, wd, fl);
    chk("mod_wb_data", {16'd0, wd}, 32'd2);
`endif
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
